// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the counter-width helper used to size the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width for a given operand width (floor of 1 bit).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the serial subtractor: the master issues
// operands with a start pulse, the slave returns busy/done and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, bin, input  busy, done, diff, bout);
  modport slave  (input  start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Purely combinational 1-bit full-subtractor cell: d = x - y - bi, with
// borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  // NOTE: continuous assigns cover every output on every path, so no latch can form.
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single
// full-subtractor cell; the result registers update only on completion.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int             CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d;
  logic             bo;

  full_subtractor u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (br),
    .d  (d),
    .bo (bo)
  );

  // NOTE: every register here uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            br       <= bus.bin;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          r_sh <= {d, r_sh[WIDTH-1:1]};
          br   <= bo;
          if (cnt == LAST) begin
            // The final bit is still in flight, so publish it straight from the cell.
            bus.diff <= {d, r_sh[WIDTH-1:1]};
            bus.bout <= bo;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 (directed + random) and
// WIDTH=3 (exhaustive), checked against plain-arithmetic reference models.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [8:0] q8[$];
  logic [3:0] q3[$];
  logic [8:0] last8 = '0;
  logic [3:0] last3 = '0;

  serial_subtractor_if #(.WIDTH(8)) bus8();
  serial_subtractor_if #(.WIDTH(3)) bus3();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {bout, diff} is a - b - bin taken modulo 2^(WIDTH+1).
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return r[8:0];
  endfunction

  function automatic logic [3:0] model3(input logic [2:0] a, input logic [2:0] b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return r[3:0];
  endfunction

  // Monitors: pop on every done pulse; otherwise the result must hold.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) last8 = '0;
      else begin
        check("busy_done_excl8", 32'(bus8.busy & bus8.done), 0);
        if (bus8.done) begin
          if (q8.size() == 0) check("unexpected_done8", 1, 0);
          else begin
            e = q8.pop_front();
            check("result8", 32'({bus8.bout, bus8.diff}), 32'(e));
            last8 = e;
          end
        end else check("hold8", 32'({bus8.bout, bus8.diff}), 32'(last8));
      end
    end
  end

  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) last3 = '0;
      else begin
        check("busy_done_excl3", 32'(bus3.busy & bus3.done), 0);
        if (bus3.done) begin
          if (q3.size() == 0) check("unexpected_done3", 1, 0);
          else begin
            e = q3.pop_front();
            check("result3", 32'({bus3.bout, bus3.diff}), 32'(e));
            last3 = e;
          end
        end else check("hold3", 32'({bus3.bout, bus3.diff}), 32'(last3));
      end
    end
  end

  // Waits for IDLE, presents operands for one accepting edge, returns at the
  // first negedge after that edge with start dropped.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit push);
    int t = 0;
    @(negedge clk);
    while ((bus8.busy || bus8.done) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle_timeout8", 1, 0);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.bin   = bin;
    @(posedge clk);
    if (push) q8.push_back(model8(a, b, bin));
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.bin   = 1'($urandom);
  endtask

  task automatic issue3(input logic [2:0] a, input logic [2:0] b, input logic bin);
    int t = 0;
    @(negedge clk);
    while ((bus3.busy || bus3.done) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle_timeout3", 1, 0);
    bus3.start = 1'b1;
    bus3.a     = a;
    bus3.b     = b;
    bus3.bin   = bin;
    @(posedge clk);
    q3.push_back(model3(a, b, bin));
    @(negedge clk);
    bus3.start = 1'b0;
    bus3.a     = 3'($urandom);
    bus3.b     = 3'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int busy_n, done_k, t, accepts, last_acc;
    rst_n      = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.bin = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus8.busy), 0);
    check("rst_done", 32'(bus8.done), 0);
    check("rst_diff", 32'(bus8.diff), 0);
    check("rst_bout", 32'(bus8.bout), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency and busy length for 0x5A - 0x3C.
    issue8(8'h5A, 8'h3C, 1'b0, 1'b1);
    busy_n = 0;
    done_k = 0;
    for (int k = 1; k <= 30 && done_k == 0; k++) begin
      if (bus8.busy) busy_n++;
      if (bus8.done) done_k = k;
      @(negedge clk);
    end
    check("busy_cycles", 32'(busy_n), 8);
    check("done_latency_negedges", 32'(done_k), 9);

    issue8(8'h00, 8'h01, 1'b0, 1'b1);
    issue8(8'h80, 8'h80, 1'b1, 1'b1);

    // Start re-asserted during RUN and during DONE must be ignored.
    issue8(8'hC3, 8'h47, 1'b1, 1'b1);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'hEE; bus8.bin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    t = 0;
    while (!bus8.done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done_seen_ignore", 32'(bus8.done), 1);
    bus8.start = 1'b1; bus8.a = 8'h22; bus8.b = 8'h99; bus8.bin = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (12) @(negedge clk);

    // Asynchronous reset in the 4th RUN cycle aborts without a done.
    issue8(8'h7E, 8'h15, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus8.busy), 0);
    check("abort_diff", 32'(bus8.diff), 0);
    check("abort_bout", 32'(bus8.bout), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue8(8'h10, 8'h01, 1'b0, 1'b1);

    for (int i = 0; i < 30; i++)
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

    // Start held high: an accept every WIDTH+2 cycles.
    @(negedge clk);
    bus8.start = 1'b1;
    accepts    = 0;
    last_acc   = -1;
    t          = 0;
    while (accepts < 6 && t < 200) begin
      bus8.a   = 8'($urandom);
      bus8.b   = 8'($urandom);
      bus8.bin = 1'($urandom);
      if (!bus8.busy && !bus8.done) begin
        q8.push_back(model8(bus8.a, bus8.b, bus8.bin));
        if (last_acc >= 0) check("b2b_interval", 32'(cyc - last_acc), 10);
        last_acc = cyc;
        accepts++;
      end
      @(negedge clk);
      t++;
    end
    bus8.start = 1'b0;
    check("b2b_accepts", 32'(accepts), 6);

    // WIDTH=3 exhaustive sweep.
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++)
          issue3(3'(a), 3'(b), 1'(c));

    t = 0;
    while ((q8.size() != 0 || q3.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", 32'(q8.size() + q3.size()), 0);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial multi-bit subtractor. It computes a − b − bin one bit per clock, LSB first, using a single 1-bit full-subtractor cell and a registered borrow. It is the sequential, inverse-direction counterpart to the parallel full adder in the arithmetic library, and is intended for area-constrained datapaths that accept multi-cycle latency. Operands are captured on a start pulse; the result is presented with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  minuend, captured when start is accepted
- b  in  WIDTH  subtrahend, captured when start is accepted
- bin  in  1  borrow-in, captured when start is accepted
- busy  out  1  high while an operation is in progress (RUN state)
- done  out  1  one-cycle pulse; diff/bout are valid from this cycle onward
- diff  out  WIDTH  registered result (a − b − bin) mod 2^WIDTH
- bout  out  1  registered borrow-out; 1 iff a < b + bin (unsigned)

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, start=1:
  - load a_sh←a, b_sh←b, br←bin, cnt←0
  - go to RUN
- IDLE, start=0: stay in IDLE.
- RUN, every cycle:
  - d = a_sh[0] ^ b_sh[0] ^ br
  - br ← (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)
  - a_sh and b_sh shift right by one
  - d shifts into the MSB of internal r_sh
  - cnt increments
- RUN, cnt == WIDTH−1: on that edge, load diff ← final r_sh value (including the current d) and bout ← new br, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- diff and bout change only on completion. Between completions they hold the last result; partial results are never visible.
- start is ignored in RUN and DONE. There is no queuing.
- A start in the first IDLE cycle after DONE is accepted.
- cnt width is $clog2(WIDTH). cnt never wraps past WIDTH−1.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - FSM→IDLE
  - busy=0, done=0, diff=0, bout=0
  - all internal shift registers, br and cnt cleared
  - the aborted operation produces no done
- Let start be accepted at rising edge E0:
  - busy=1 from E0 to E_WIDTH (exactly WIDTH cycles)
  - diff/bout update at E_WIDTH
  - done=1 from E_WIDTH to E_WIDTH+1
- Latency: start edge to done rising = WIDTH cycles. Minimum issue interval = WIDTH+2 cycles.
- busy and done are never high together. Both are registered (Moore) outputs.
- Operand inputs are don't-care except at the accepting edge.

## Structure
- Shared arithmetic package holds:
  - state typedef (IDLE/RUN/DONE)
  - localparam CNT_W = $clog2(WIDTH)
- Sub-module full_subtractor: purely combinational 1-bit cell, x, y, bi → d, bo. It is instantiated once and reusable elsewhere in the library.
- Top level holds the FSM, counter, shift registers, borrow flop and output registers.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, bin=0 → diff=0x1E, bout=0; done exactly 8 cycles after the start edge; busy high for 8 cycles.
- WIDTH=8, a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0x80, b=0x80, bin=1 → diff=0xFF, bout=1.
- Start re-asserted during RUN and during DONE with different operands → ignored; the result matches the first operands; only one done pulse.
- rst_n low for one cycle at the 4th RUN cycle → busy=0 immediately; diff=0, bout=0; no done. A subsequent start with a=0x10, b=0x01 → diff=0x0F, bout=0.
- Back-to-back: start held high continuously → operations issue every WIDTH+2 cycles; each result is correct; diff stays stable between done pulses.
- WIDTH=3, exhaustive over all a, b, bin (128 cases) → {bout,diff} equals (a − b − bin) mod 16 against a reference model.
